// File: rtl/bridge_pkg.sv
// Shared definitions for the byte-stream Wishbone master.
// Holds the command and response byte codes of the host protocol and the
// parser/bus-engine state encoding used by wb_byte_master.
package bridge_pkg;

   // Host protocol byte codes
   localparam logic [7:0] CMD_WR  = 8'h57;   // 'W': cmd + 4 addr + 4 data
   localparam logic [7:0] CMD_RD  = 8'h52;   // 'R': cmd + 4 addr
   localparam logic [7:0] RSP_OK  = 8'h4B;   // 'K': write acknowledged
   localparam logic [7:0] RSP_ERR = 8'h45;   // 'E': bus cycle timed out

   // State encoding
   localparam logic [2:0] ST_IDLE_C = 3'd0;
   localparam logic [2:0] ST_ADDR_C = 3'd1;
   localparam logic [2:0] ST_DATA_C = 3'd2;
   localparam logic [2:0] ST_BUS_C  = 3'd3;
   localparam logic [2:0] ST_RESP_C = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE = ST_IDLE_C,
      ST_ADDR = ST_ADDR_C,
      ST_DATA = ST_DATA_C,
      ST_BUS  = ST_BUS_C,
      ST_RESP = ST_RESP_C
   } state_e;

endpackage

// File: rtl/wb_byte_master_resp.sv
// Response serializer: sends 1 or 4 bytes of a 32-bit word, MSB first,
// over a valid/ready byte handshake.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   load_i       : one-cycle request to start sending word_i
//   len4_i       : 1 -> send all four bytes, 0 -> send only word_i[31:24]
//   word_i       : response word
//   tx_ready_i   : sink accepts the presented byte
//   tx_data_o    : presented byte (registered)
//   tx_valid_o   : presented byte valid (registered), held until accepted
//   done_o       : the last byte is being accepted this cycle
module wb_byte_master_resp
   import bridge_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load_i,
   input  logic        len4_i,
   input  logic [31:0] word_i,
   input  logic        tx_ready_i,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   output logic        done_o
);

   logic [31:0] shreg_q, shreg_d;
   logic [1:0]  left_q, left_d;    // bytes still to follow the presented one
   logic        valid_q, valid_d;

   // Next-state: load a new word, or advance one byte per accepted handshake
   always_comb begin
      shreg_d = shreg_q;
      left_d  = left_q;
      valid_d = valid_q;
      if (load_i) begin
         shreg_d = word_i;
         left_d  = len4_i ? 2'd3 : 2'd0;
         valid_d = 1'b1;
      end else if (valid_q && tx_ready_i) begin
         if (left_q == 2'd0) begin
            valid_d = 1'b0;
         end else begin
            shreg_d = {shreg_q[23:0], 8'h00};
            left_d  = left_q - 2'd1;
         end
      end else begin
         valid_d = valid_q;
      end
   end

   // Serializer state registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg_q <= 32'h0000_0000;
         left_q  <= 2'd0;
         valid_q <= 1'b0;
      end else begin
         shreg_q <= shreg_d;
         left_q  <= left_d;
         valid_q <= valid_d;
      end
   end

   assign tx_data_o  = shreg_q[31:24];
   assign tx_valid_o = valid_q;
   assign done_o     = valid_q & tx_ready_i & (left_q == 2'd0);

endmodule

// File: rtl/wb_byte_master.sv
// Byte-stream driven Wishbone initiator. Parses 'W'/'R' frames from a byte
// source, runs one classic 32-bit Wishbone cycle per frame and returns a
// status byte or the read data through a valid/ready byte sink.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   rx_data, rx_valid    : incoming bytes, one-cycle strobe, no backpressure
//   tx_data, tx_valid    : outgoing bytes, held until tx_ready
//   tx_ready             : sink ready
//   wb_adr_o .. wb_stb_o : Wishbone master outputs (sel is 4'hF during a cycle)
//   wb_dat_i, wb_ack_i   : Wishbone slave response
//   busy                 : high whenever the engine is not idle
module wb_byte_master
   import bridge_pkg::*;
#(
   parameter int unsigned WB_TIMEOUT    = 1024,
   parameter int unsigned FRAME_TIMEOUT = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic        wb_ack_i,
   output logic        busy
);

   localparam int unsigned WBW = $clog2(WB_TIMEOUT);
   localparam int unsigned FTW = $clog2(FRAME_TIMEOUT);
   localparam logic [WBW-1:0] WB_LAST = WBW'(WB_TIMEOUT - 1);
   localparam logic [WBW-1:0] WB_ONE  = WBW'(1);
   localparam logic [FTW-1:0] FT_LAST = FTW'(FRAME_TIMEOUT - 1);
   localparam logic [FTW-1:0] FT_ONE  = FTW'(1);

   state_e          state_q, state_d;
   logic [1:0]      bcnt_q, bcnt_d;
   logic            is_wr_q, is_wr_d;
   logic [31:0]     adr_q, adr_d;
   logic [31:0]     dat_q, dat_d;
   logic [WBW-1:0]  wbcnt_q, wbcnt_d;
   logic [FTW-1:0]  ftcnt_q, ftcnt_d;
   logic            cyc_q, cyc_d;
   logic            we_q, we_d;
   logic [3:0]      sel_q, sel_d;
   logic [31:0]     rsp_word_q, rsp_word_d;
   logic            rsp_len4_q, rsp_len4_d;
   logic            rsp_started_q, rsp_started_d;
   logic            busy_q;
   logic            ser_load_s;
   logic            ser_done_s;

   // Frame parser, bus engine and response sequencing
   always_comb begin
      state_d       = state_q;
      bcnt_d        = bcnt_q;
      is_wr_d       = is_wr_q;
      adr_d         = adr_q;
      dat_d         = dat_q;
      wbcnt_d       = wbcnt_q;
      ftcnt_d       = ftcnt_q;
      cyc_d         = cyc_q;
      we_d          = we_q;
      sel_d         = sel_q;
      rsp_word_d    = rsp_word_q;
      rsp_len4_d    = rsp_len4_q;
      rsp_started_d = rsp_started_q;
      ser_load_s    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rx_valid && ((rx_data == CMD_WR) || (rx_data == CMD_RD))) begin
               is_wr_d = (rx_data == CMD_WR);
               bcnt_d  = 2'd0;
               ftcnt_d = {FTW{1'b0}};
               state_d = ST_ADDR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ADDR, ST_DATA: begin
            if (ftcnt_q == FT_LAST) begin
               // Stale partial frame; a byte arriving now is dropped too
               ftcnt_d = {FTW{1'b0}};
               bcnt_d  = 2'd0;
               state_d = ST_IDLE;
            end else if (rx_valid) begin
               ftcnt_d = {FTW{1'b0}};
               bcnt_d  = bcnt_q + 2'd1;
               if (state_q == ST_ADDR) begin
                  adr_d = {adr_q[23:0], rx_data};
               end else begin
                  dat_d = {dat_q[23:0], rx_data};
               end
               if (bcnt_q == 2'd3) begin
                  if ((state_q == ST_ADDR) && is_wr_q) begin
                     state_d = ST_DATA;
                  end else begin
                     state_d = ST_BUS;
                     cyc_d   = 1'b1;
                     we_d    = is_wr_q;
                     sel_d   = 4'hF;
                     wbcnt_d = {WBW{1'b0}};
                  end
               end else begin
                  state_d = state_q;
               end
            end else begin
               ftcnt_d = ftcnt_q + FT_ONE;
            end
         end
         ST_BUS: begin
            // A same-cycle ack takes priority over the timeout
            if (wb_ack_i || (wbcnt_q == WB_LAST)) begin
               cyc_d         = 1'b0;
               we_d          = 1'b0;
               sel_d         = 4'h0;
               rsp_started_d = 1'b0;
               state_d       = ST_RESP;
               if (!wb_ack_i) begin
                  rsp_word_d = {RSP_ERR, 24'h00_0000};
                  rsp_len4_d = 1'b0;
               end else if (is_wr_q) begin
                  rsp_word_d = {RSP_OK, 24'h00_0000};
                  rsp_len4_d = 1'b0;
               end else begin
                  rsp_word_d = wb_dat_i;
                  rsp_len4_d = 1'b1;
               end
            end else begin
               wbcnt_d = wbcnt_q + WB_ONE;
            end
         end
         ST_RESP: begin
            // One idle cycle in RESP before the serializer loads
            if (!rsp_started_q) begin
               ser_load_s    = 1'b1;
               rsp_started_d = 1'b1;
            end else if (ser_done_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cyc_d   = 1'b0;
            we_d    = 1'b0;
            sel_d   = 4'h0;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         bcnt_q        <= 2'd0;
         is_wr_q       <= 1'b0;
         adr_q         <= 32'h0000_0000;
         dat_q         <= 32'h0000_0000;
         wbcnt_q       <= {WBW{1'b0}};
         ftcnt_q       <= {FTW{1'b0}};
         cyc_q         <= 1'b0;
         we_q          <= 1'b0;
         sel_q         <= 4'h0;
         rsp_word_q    <= 32'h0000_0000;
         rsp_len4_q    <= 1'b0;
         rsp_started_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         bcnt_q        <= bcnt_d;
         is_wr_q       <= is_wr_d;
         adr_q         <= adr_d;
         dat_q         <= dat_d;
         wbcnt_q       <= wbcnt_d;
         ftcnt_q       <= ftcnt_d;
         cyc_q         <= cyc_d;
         we_q          <= we_d;
         sel_q         <= sel_d;
         rsp_word_q    <= rsp_word_d;
         rsp_len4_q    <= rsp_len4_d;
         rsp_started_q <= rsp_started_d;
         busy_q        <= (state_d != ST_IDLE);
      end
   end

   wb_byte_master_resp u_resp (
      .clk        (clk),
      .reset      (reset),
      .load_i     (ser_load_s),
      .len4_i     (rsp_len4_q),
      .word_i     (rsp_word_q),
      .tx_ready_i (tx_ready),
      .tx_data_o  (tx_data),
      .tx_valid_o (tx_valid),
      .done_o     (ser_done_s)
   );

   assign wb_adr_o = adr_q;
   assign wb_dat_o = dat_q;
   assign wb_sel_o = sel_q;
   assign wb_we_o  = we_q;
   assign wb_cyc_o = cyc_q;
   assign wb_stb_o = cyc_q;
   assign busy     = busy_q;

endmodule
